pow2_deser: RTL and testbench

- Serial-to-parallel front end for the power-of-two checker path.
- Assembles W-bit frames from a serial bit stream. Each completed frame is classified as having exactly one bit set (power of two) or not.
- Presents the word, the classification and the set-bit index with a one-cycle valid strobe.
- Keeps saturating statistics counters. Sits directly upstream of the one-hot detector and feeds its [0:W-1] word.

---
 rtl/pow2_deser.sv | 153 +++++++++++++++
 tb/tb_pow2_deser.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pow2_deser.sv
// Serial-to-parallel frame assembler with power-of-two classification and
// saturating frame statistics; feeds the downstream one-hot detector.
module pow2_deser #(
  parameter  int W     = 8,
  parameter  int CNT_W = 16,
  localparam int EW    = $clog2(W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             sof,
  input  logic             clear,
  output logic [0:W-1]     word_out,
  output logic             word_valid,
  output logic             is_pow2,
  output logic [EW-1:0]    exp_out,
  output logic             frame_err,
  output logic [CNT_W-1:0] word_count,
  output logic [CNT_W-1:0] pow2_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [EW-1:0] LAST_IDX = EW'(W - 1);

  state_t             state_q, state_d;
  logic [EW-1:0]      idx_q, idx_d;
  logic [0:W-1]       buf_q, buf_d;
  logic [0:W-1]       frame;
  logic               done;
  logic               err_d;
  logic [EW:0]        cls;

  logic [0:W-1]       word_q;
  logic               word_valid_q;
  logic               is_pow2_q;
  logic [EW-1:0]      exp_q;
  logic               frame_err_q;
  logic [CNT_W-1:0]   word_count_q;
  logic [CNT_W-1:0]   pow2_count_q;

  // Returns {is_pow2, index}; the population count saturates at 2 since only
  // "exactly one" matters.
  function automatic logic [EW:0] classify(input logic [0:W-1] f);
    logic [1:0]    cnt;
    logic [EW-1:0] pos;
    cnt = 2'd0;
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (f[i]) begin
        if (cnt != 2'd2) cnt = cnt + 2'd1;
        pos = EW'(i);
      end
    end
    if (cnt == 2'd1) return {1'b1, pos};
    else             return '0;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    frame   = buf_q;
    done    = 1'b0;
    err_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      idx_d   = '0;
      buf_d   = '0;
    end else if (bit_valid) begin
      case (state_q)
        IDLE: begin
          if (sof) begin
            buf_d    = '0;
            buf_d[0] = bit_in;
            idx_d    = EW'(1);
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          if (sof) begin
            // Abort the partial frame; the sof bit starts the new one.
            buf_d    = '0;
            buf_d[0] = bit_in;
            idx_d    = EW'(1);
            err_d    = 1'b1;
          end else begin
            buf_d[idx_q] = bit_in;
            if (idx_q == LAST_IDX) begin
              frame   = buf_d;
              done    = 1'b1;
              idx_d   = '0;
              state_d = IDLE;
            end else begin
              idx_d = idx_q + EW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cls = classify(frame);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      buf_q        <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      is_pow2_q    <= 1'b0;
      exp_q        <= '0;
      frame_err_q  <= 1'b0;
      word_count_q <= '0;
      pow2_count_q <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      word_valid_q <= done;
      frame_err_q  <= err_d;
      if (clear) begin
        word_q       <= '0;
        is_pow2_q    <= 1'b0;
        exp_q        <= '0;
        word_count_q <= '0;
        pow2_count_q <= '0;
      end else if (done) begin
        word_q       <= frame;
        is_pow2_q    <= cls[EW];
        exp_q        <= cls[EW-1:0];
        word_count_q <= sat_inc(word_count_q);
        if (cls[EW]) pow2_count_q <= sat_inc(pow2_count_q);
      end
    end
  end

  assign word_out   = word_q;
  assign word_valid = word_valid_q;
  assign is_pow2    = is_pow2_q;
  assign exp_out    = exp_q;
  assign frame_err  = frame_err_q;
  assign word_count = word_count_q;
  assign pow2_count = pow2_count_q;

endmodule

// File: tb/tb_pow2_deser.sv
// Directed bench for pow2_deser: default instance plus a CNT_W=2 instance for
// counter saturation, both driven by the same serial stream.
module tb_pow2_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bit_in, bit_valid, sof, clear;

  logic [0:7]  word_out;
  logic        word_valid, is_pow2, frame_err;
  logic [2:0]  exp_out;
  logic [15:0] word_count, pow2_count;

  logic [0:7]  word_out2;
  logic        word_valid2, is_pow22, frame_err2;
  logic [2:0]  exp_out2;
  logic [1:0]  word_count2, pow2_count2;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int last_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pow2_deser #(.W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .sof(sof), .clear(clear), .word_out(word_out), .word_valid(word_valid),
    .is_pow2(is_pow2), .exp_out(exp_out), .frame_err(frame_err),
    .word_count(word_count), .pow2_count(pow2_count)
  );

  pow2_deser #(.W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .sof(sof), .clear(clear), .word_out(word_out2), .word_valid(word_valid2),
    .is_pow2(is_pow22), .exp_out(exp_out2), .frame_err(frame_err2),
    .word_count(word_count2), .pow2_count(pow2_count2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      $error("%s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic v, input logic b, input logic s, input logic c);
    @(negedge clk);
    bit_valid = v;
    bit_in    = b;
    sof       = s;
    clear     = c;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [0:7] f, input int gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, f[i], (i == 0), 1'b0);
      if (i < 7) for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_word"}, 32'(word_out), 32'h0);
    check({tag, "_wv"},   32'(word_valid), 32'h0);
    check({tag, "_p2"},   32'(is_pow2), 32'h0);
    check({tag, "_exp"},  32'(exp_out), 32'h0);
    check({tag, "_ferr"}, 32'(frame_err), 32'h0);
    check({tag, "_wc"},   32'(word_count), 32'h0);
    check({tag, "_pc"},   32'(pow2_count), 32'h0);
  endtask

  initial begin
    logic [0:7] f;
    rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; sof = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk) rst_n = 1'b1;

    // Single power-of-two frame, no gaps.
    send_frame(8'b0001_0000, 0);
    check("t1_wv",   32'(word_valid), 32'h1);
    check("t1_word", 32'(word_out), 32'h10);
    check("t1_p2",   32'(is_pow2), 32'h1);
    check("t1_exp",  32'(exp_out), 32'd3);
    check("t1_wc",   32'(word_count), 32'd1);
    check("t1_pc",   32'(pow2_count), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t1_wv_pulse", 32'(word_valid), 32'h0);
    check("t1_hold",     32'(word_out), 32'h10);

    // Clear, then zero / multi-bit / last-bit frames.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    check("clr_wc",   32'(word_count), 32'd0);
    check("clr_word", 32'(word_out), 32'h0);
    send_frame(8'b0000_0000, 0);
    check("t2a_wv",  32'(word_valid), 32'h1);
    check("t2a_p2",  32'(is_pow2), 32'h0);
    check("t2a_exp", 32'(exp_out), 32'd0);
    send_frame(8'b1000_0001, 0);
    check("t2b_p2",   32'(is_pow2), 32'h0);
    check("t2b_exp",  32'(exp_out), 32'd0);
    check("t2b_word", 32'(word_out), 32'h81);
    send_frame(8'b0000_0001, 0);
    check("t2c_p2",  32'(is_pow2), 32'h1);
    check("t2c_exp", 32'(exp_out), 32'd7);
    check("t2c_wc",  32'(word_count), 32'd3);
    check("t2c_pc",  32'(pow2_count), 32'd1);

    // Partial frame of 5 bits aborted by a new sof.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_noerr", 32'(frame_err), 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    check("t3_ferr",    32'(frame_err), 32'h1);
    check("t3_ferr_wv", 32'(word_valid), 32'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t3_ferr_pulse", 32'(frame_err), 32'h0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t3_wv",   32'(word_valid), 32'h1);
    check("t3_word", 32'(word_out), 32'h40);
    check("t3_exp",  32'(exp_out), 32'd1);
    check("t3_wc",   32'(word_count), 32'd1);

    // Gapped frame, then ten back-to-back frames.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'b0010_0000, 3);
    check("t4_gap_wv",  32'(word_valid), 32'h1);
    check("t4_gap_p2",  32'(is_pow2), 32'h1);
    check("t4_gap_exp", 32'(exp_out), 32'd2);
    check("t4_gap_wc",  32'(word_count), 32'd1);
    last_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      f = (k < 8) ? (8'b1000_0000 >> k) : 8'hFF;
      send_frame(f, 0);
      check("t4_b2b_wv",  32'(word_valid), 32'h1);
      check("t4_b2b_p2",  32'(is_pow2), (k < 8) ? 32'h1 : 32'h0);
      check("t4_b2b_exp", 32'(exp_out), (k < 8) ? 32'(k) : 32'h0);
      check("t4_b2b_spacing", 32'(cyc - last_cyc), 32'd8);
      last_cyc = cyc;
    end
    check("t4_wc", 32'(word_count), 32'd11);
    check("t4_pc", 32'(pow2_count), 32'd9);

    // Saturation: the CNT_W=2 instance must stick at 3.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) send_frame(8'b0000_0100, 0);
    check("t5_wc16",  32'(word_count), 32'd5);
    check("t5_pc16",  32'(pow2_count), 32'd5);
    check("t5_wc2",   32'(word_count2), 32'd3);
    check("t5_pc2",   32'(pow2_count2), 32'd3);
    check("t5_wv2",   32'(word_valid2), 32'h1);
    check("t5_word2", 32'(word_out2), 32'h04);
    check("t5_p22",   32'(is_pow22), 32'h1);
    check("t5_exp2",  32'(exp_out2), 32'd5);
    check("t5_ferr2", 32'(frame_err2), 32'h0);

    // Asynchronous reset in mid-frame.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    bit_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check_outputs_zero("t6_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t6_rst_wv", 32'(word_valid), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_nostrobe", 32'(word_valid), 32'h0);
    check("t6_nocount",  32'(word_count), 32'd0);
    send_frame(8'b0000_0010, 0);
    check("t6_wv",  32'(word_valid), 32'h1);
    check("t6_p2",  32'(is_pow2), 32'h1);
    check("t6_exp", 32'(exp_out), 32'd6);
    check("t6_wc",  32'(word_count), 32'd1);
    check("t6_pc",  32'(pow2_count), 32'd1);

    // Clear coinciding with the last bit drops the frame.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t7_wv",   32'(word_valid), 32'h0);
    check("t7_wc",   32'(word_count), 32'd0);
    check("t7_pc",   32'(pow2_count), 32'd0);
    check("t7_word", 32'(word_out), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("t7_wv_after", 32'(word_valid), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
